// File: rtl/jailbreak_dip_bank.sv
// Bank of shadow/live DIP-switch registers written over a bridge; commits copy shadow to live at a safe point or after TIMEOUT.
// Optional macro JAILBREAK_DIP_AUTOCOMMIT_EN: every accepted shadow write also requests a commit.
module jailbreak_dip_bank #(
    parameter int                          NUM_REGS = 4,
    parameter int                          WIDTH    = 32,
    parameter logic [NUM_REGS*WIDTH-1:0]   DEFAULTS = '0,
    parameter int unsigned                 TIMEOUT  = 1000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   bridge_addr,
    input  logic                          bridge_wr,
    input  logic [31:0]                   bridge_wr_data,
    output logic [31:0]                   bridge_rd_data,
    input  logic                          safe_point,
    output logic [NUM_REGS*WIDTH-1:0]     dip_switches,
    output logic [NUM_REGS-1:0]           changed,
    output logic [1:0]                    dbg_state_o
);

    // Handshake: bridge_wr is a single-cycle strobe, no backpressure; read data follows the address one cycle later.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } state_t;

    localparam logic [5:0]  CTRL_IDX     = 6'(NUM_REGS);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                dirty_q;
    logic [31:0]         rd_q, rd_d;
    logic [NUM_REGS-1:0] changed_q, changed_d;
    logic [WIDTH-1:0]    shadow_q [NUM_REGS];
    logic [WIDTH-1:0]    live_q   [NUM_REGS];

    logic [5:0] word_idx;
    logic       shadow_wr;
    logic       ctrl_commit;
    logic       commit_req;
    logic       apply;
    logic       unused_bits;

    assign word_idx    = bridge_addr[7:2];
    assign shadow_wr   = bridge_wr && (word_idx < CTRL_IDX);
    assign ctrl_commit = bridge_wr && (word_idx == CTRL_IDX) && bridge_wr_data[0];
    assign unused_bits = ^{bridge_addr[31:8], bridge_addr[1:0], bridge_wr_data};

`ifdef JAILBREAK_DIP_AUTOCOMMIT_EN
    assign commit_req = ctrl_commit || shadow_wr;
`else
    assign commit_req = ctrl_commit;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        apply   = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d = ARMED;
                    cnt_d   = 32'd0;
                end
            end
            ARMED: begin
                cnt_d = cnt_q + 32'd1;
                if (safe_point || (cnt_q == TIMEOUT_LAST)) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                apply   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d      = 32'd0;
        changed_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            changed_d[i] = (live_q[i] != shadow_q[i]);
            if (word_idx == 6'(i)) begin
                rd_d = 32'(shadow_q[i]);
            end
        end
        if (word_idx == CTRL_IDX) begin
            rd_d = {30'd0, dirty_q, (state_q == ARMED)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            dirty_q   <= 1'b0;
            rd_q      <= 32'd0;
            changed_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= DEFAULTS[i*WIDTH +: WIDTH];
                live_q[i]   <= DEFAULTS[i*WIDTH +: WIDTH];
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            changed_q <= apply ? changed_d : '0;
            // A write landing in the APPLY cycle keeps dirty set; live sees the pre-write shadow.
            if (shadow_wr) begin
                dirty_q <= 1'b1;
            end else if (apply) begin
                dirty_q <= 1'b0;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (shadow_wr && (word_idx == 6'(i))) begin
                    shadow_q[i] <= bridge_wr_data[WIDTH-1:0];
                end
                if (apply) begin
                    live_q[i] <= shadow_q[i];
                end
            end
        end
    end

    always_comb begin
        dip_switches = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            dip_switches[i*WIDTH +: WIDTH] = live_q[i];
        end
    end

    assign bridge_rd_data = rd_q;
    assign changed        = changed_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_jailbreak_dip_bank.sv
// Self-checking bench for jailbreak_dip_bank: cycle model of the bank plus directed commit/timeout/reset scenarios.
module tb_jailbreak_dip_bank;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;
  localparam logic [N*W-1:0] DEF = 128'h00000000_00000033_00000000_000000A5;

  logic           clk = 1'b0;
  logic           reset;
  logic [31:0]    bridge_addr;
  logic           bridge_wr;
  logic [31:0]    bridge_wr_data;
  logic [31:0]    bridge_rd_data;
  logic           safe_point;
  logic [N*W-1:0] dip_switches;
  logic [N-1:0]   changed;
  logic [1:0]     dbg_state_o;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  jailbreak_dip_bank #(
    .NUM_REGS (N),
    .WIDTH    (W),
    .DEFAULTS (DEF),
    .TIMEOUT  (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bridge_addr    (bridge_addr),
    .bridge_wr      (bridge_wr),
    .bridge_wr_data (bridge_wr_data),
    .bridge_rd_data (bridge_rd_data),
    .safe_point     (safe_point),
    .dip_switches   (dip_switches),
    .changed        (changed),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: shadow/live arrays, a pending-commit age and an apply flag
  logic [W-1:0] m_shadow [N];
  logic [W-1:0] m_live   [N];
  bit           m_dirty;
  int           m_age;
  bit           m_apply;
  logic [31:0]  m_rd;
  logic [N-1:0] m_changed;
  int           widx;
  bit           do_sw;
  bit           do_commit;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_shadow[i] = DEF[i*W +: W];
        m_live[i]   = DEF[i*W +: W];
      end
      m_dirty   = 1'b0;
      m_age     = -1;
      m_apply   = 1'b0;
      m_rd      = 32'd0;
      m_changed = '0;
    end else begin
      widx      = int'(bridge_addr[7:2]);
      do_sw     = bridge_wr && (widx < N);
      do_commit = bridge_wr && (widx == N) && bridge_wr_data[0];
`ifdef JAILBREAK_DIP_AUTOCOMMIT_EN
      do_commit = do_commit || do_sw;
`endif
      m_rd = 32'd0;
      if (widx < N) m_rd = m_shadow[widx];
      else if (widx == N) m_rd = {30'd0, m_dirty, (m_age >= 0)};
      m_changed = '0;
      if (m_apply) begin
        for (int i = 0; i < N; i++) begin
          if (m_live[i] != m_shadow[i]) m_changed[i] = 1'b1;
          m_live[i] = m_shadow[i];
        end
        m_dirty = 1'b0;
        m_apply = 1'b0;
      end else if (m_age >= 0) begin
        if (safe_point || (m_age == TO - 1)) begin
          m_apply = 1'b1;
          m_age   = -1;
        end else begin
          m_age++;
        end
      end else if (do_commit) begin
        m_age = 0;
      end
      if (do_sw) begin
        m_shadow[widx] = bridge_wr_data;
        m_dirty        = 1'b1;
      end
    end
  end

  // scoreboard: every cycle, compare outputs against the model
  logic [N*W-1:0] exp_dip;
  logic [1:0]     exp_state;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < N; i++) exp_dip[i*W +: W] = m_live[i];
      exp_state = m_apply ? 2'd2 : ((m_age >= 0) ? 2'd1 : 2'd0);
      check("cyc_dip", dip_switches, exp_dip);
      check("cyc_changed", changed, m_changed);
      check("cyc_rd", bridge_rd_data, m_rd);
      check("cyc_state", dbg_state_o, exp_state);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int n;
  int pulses;

  initial begin
    reset          = 1'b1;
    bridge_addr    = 32'd0;
    bridge_wr      = 1'b0;
    bridge_wr_data = 32'd0;
    safe_point     = 1'b0;
    chk_en         = 1'b1;
    step();
    step();
    check("rst_dip", dip_switches, DEF);
    check("rst_changed", changed, 4'b0000);
    check("rst_rd", bridge_rd_data, 32'd0);
    check("rst_state", dbg_state_o, 2'd0);
    reset = 1'b0;
    step();
    check("def_rd0", bridge_rd_data, 32'h000000A5);
    check("def_dip0", dip_switches[31:0], 32'h000000A5);

`ifndef JAILBREAK_DIP_AUTOCOMMIT_EN
    // shadow write without commit
    bridge_addr = 32'h4; bridge_wr = 1'b1; bridge_wr_data = 32'h1234;
    step();
    bridge_wr = 1'b0;
    step();
    check("shadow_rd1", bridge_rd_data, 32'h1234);
    check("live1_unchanged", dip_switches[63:32], 32'h0);
    bridge_addr = 32'h10;
    step();
    check("ctrl_dirty", bridge_rd_data, 32'h2);

    // commit then safe_point a few cycles later
    bridge_wr = 1'b1; bridge_wr_data = 32'h1;
    step();
    bridge_wr = 1'b0;
    step();
    check("ctrl_armed", bridge_rd_data, 32'h3);
    step(); step(); step();
    safe_point = 1'b1;
    step();
    safe_point = 1'b0;
    check("live1_before_apply", dip_switches[63:32], 32'h0);
    step();
    check("commit_live1", dip_switches[63:32], 32'h1234);
    check("commit_changed", changed, 4'b0010);
    step();
    check("changed_pulse_end", changed, 4'b0000);
    check("ctrl_clear", bridge_rd_data, 32'h0);

    // timeout commit with no safe_point
    bridge_addr = 32'hC; bridge_wr = 1'b1; bridge_wr_data = 32'hBEEF;
    step();
    bridge_addr = 32'h10; bridge_wr_data = 32'h1;
    step();
    bridge_wr = 1'b0;
    n = 0;
    while (changed == '0 && n < 20) begin
      step();
      n++;
    end
    check("timeout_cycles", 128'(n), 128'd9);
    check("timeout_changed", changed, 4'b1000);
    check("timeout_live3", dip_switches[127:96], 32'hBEEF);

    // second commit while armed does not restart the wait
    bridge_addr = 32'hC; bridge_wr = 1'b1; bridge_wr_data = 32'hCAFE;
    step();
    bridge_addr = 32'h10; bridge_wr_data = 32'h1;
    step();
    bridge_wr = 1'b0;
    step(); step(); step();
    bridge_wr = 1'b1;
    step();
    bridge_wr = 1'b0;
    n = 4;
    while (changed == '0 && n < 20) begin
      step();
      n++;
    end
    check("no_restart_cycles", 128'(n), 128'd9);
    check("no_restart_live3", dip_switches[127:96], 32'hCAFE);

    // shadow write coinciding with APPLY
    bridge_addr = 32'h0; bridge_wr = 1'b1; bridge_wr_data = 32'h11;
    step();
    bridge_addr = 32'h10; bridge_wr_data = 32'h1;
    step();
    bridge_wr = 1'b0; safe_point = 1'b1;
    step();
    safe_point = 1'b0;
    bridge_addr = 32'h0; bridge_wr = 1'b1; bridge_wr_data = 32'h22;
    step();
    bridge_wr = 1'b0; bridge_addr = 32'h10;
    check("coinc_live0", dip_switches[31:0], 32'h11);
    check("coinc_changed", changed, 4'b0001);
    step();
    check("coinc_ctrl", bridge_rd_data, 32'h2);
    bridge_addr = 32'h0;
    step();
    check("coinc_shadow0", bridge_rd_data, 32'h22);

    // out-of-range writes and safe_point while idle
    bridge_addr = 32'h14; bridge_wr = 1'b1; bridge_wr_data = 32'hFFFFFFFF;
    step();
    bridge_addr = 32'hFC;
    step();
    bridge_wr = 1'b0; bridge_addr = 32'h14;
    step();
    check("oob_rd", bridge_rd_data, 32'h0);
    safe_point = 1'b1;
    step();
    safe_point = 1'b0;
    step();
    check("idle_safe_live0", dip_switches[31:0], 32'h11);

    // reset while armed aborts the commit
    bridge_addr = 32'h8; bridge_wr = 1'b1; bridge_wr_data = 32'h77;
    step();
    bridge_addr = 32'h10; bridge_wr_data = 32'h1;
    step();
    bridge_wr = 1'b0;
    step();
    check("pre_reset_armed", dbg_state_o, 2'd1);
    reset = 1'b1;
    step();
    check("abort_state", dbg_state_o, 2'd0);
    check("abort_dip", dip_switches, DEF);
    reset = 1'b0; bridge_addr = 32'h8;
    step();
    check("abort_shadow2", bridge_rd_data, 32'h33);
`else
    // autocommit: a shadow write arms, reset aborts it
    bridge_addr = 32'h0; bridge_wr = 1'b1; bridge_wr_data = 32'h1;
    step();
    bridge_wr = 1'b0;
    step();
    check("auto_armed", dbg_state_o, 2'd1);
    step();
    reset = 1'b1;
    step();
    check("auto_abort_state", dbg_state_o, 2'd0);
    check("auto_abort_live0", dip_switches[31:0], 32'hA5);
    reset = 1'b0;
    step();
`endif

    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (changed != '0) pulses++;
    end
    check("no_changed_after_abort", 128'(pulses), 128'd0);
    check("final_live0_default_or_kept", dip_switches[31:0], 32'hA5);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jailbreak_dip_bank.md
JAILBREAK_DIP_BANK -- requirements
Module: jailbreak_dip_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of switch registers (1..16).
REQ-002 SHALL have parameter WIDTH, default 32, bits per register (1..32).
REQ-003 SHALL have parameter DEFAULTS, default 0, packed NUM_REGS*WIDTH reset value, register 0 in LSBs.
REQ-004 SHALL have parameter TIMEOUT, default 1000000, max cycles an armed commit waits for safe_point (>=1).
REQ-005 SHALL have port clk  in  1  single clock for all logic.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port bridge_addr  in  32  byte address; word index = bridge_addr[7:2].
REQ-008 SHALL have port bridge_wr  in  1  write strobe, one cycle per write.
REQ-009 SHALL have port bridge_wr_data  in  32  write data.
REQ-010 SHALL have port bridge_rd_data  out  32  registered read data for bridge_addr.
REQ-011 SHALL have port safe_point  in  1  one-cycle pulse marking a point where switches may change (e.g. vblank).
REQ-012 SHALL have port dip_switches  out  NUM_REGS*WIDTH  live switch values driving the core.
REQ-013 SHALL have port changed  out  NUM_REGS  one-cycle pulse per register whose live value changed.

Function
REQ-014 SHALL hold a shadow register and a live register per index; dip_switches SHALL be the live registers.
REQ-015 SHALL write shadow[i] <= bridge_wr_data[WIDTH-1:0] when bridge_wr and word index i < NUM_REGS, and set dirty.
REQ-016 SHALL decode word index NUM_REGS as CTRL: write with bit0=1 is a commit request; other bits ignored.
REQ-017 SHALL ignore writes to word indices above NUM_REGS.
REQ-018 SHALL update bridge_rd_data every cycle, one-cycle latency: shadow[i] zero-extended for i<NUM_REGS; CTRL reads {30'b0, dirty, armed}; other indices read 0.
REQ-019 SHALL implement states IDLE, ARMED, APPLY.
REQ-020 IDLE -> ARMED on commit request; wait counter cleared to 0.
REQ-021 ARMED -> APPLY on safe_point, or when wait counter reaches TIMEOUT-1; counter increments each ARMED cycle.
REQ-022 APPLY SHALL last one cycle: live <= shadow for all registers, changed[i] pulsed for each i with live!=shadow, dirty cleared, then -> IDLE.
REQ-023 Commit request while ARMED or APPLY SHALL be ignored, no counter restart.
REQ-024 Shadow write in same cycle as APPLY: live SHALL take the pre-write shadow value; dirty SHALL remain set.
REQ-025 safe_point in IDLE SHALL have no effect; live registers change only in APPLY.
REQ-026 changed SHALL be 0 in all cycles other than the one following APPLY's register update (pulse width exactly one cycle).

Reset
REQ-027 On reset: shadow and live = DEFAULTS, state IDLE, counter 0, dirty 0, changed 0, bridge_rd_data 0.
REQ-028 Reset mid-ARMED SHALL abort the commit; pending shadow writes are discarded.

Configuration
REQ-029 Macro JAILBREAK_DIP_AUTOCOMMIT_EN: when defined, every accepted shadow write SHALL also act as a commit request (REQ-020/023 apply).
REQ-030 Without JAILBREAK_DIP_AUTOCOMMIT_EN, commits SHALL occur only via CTRL bit0.

Verification
REQ-031 Reset with DEFAULTS=0x...0000_00A5 (reg0) -> dip_switches reg0=0xA5, rd_data at addr 0x0 = 0xA5 next cycle.
REQ-032 Write 0x1234 to addr 0x4, no commit -> live reg1 unchanged, CTRL read = 0x2, shadow read = 0x1234.
REQ-033 Write 0x1234 to 0x4, commit (NUM_REGS=4, write 0x1 to 0x10), safe_point 5 cycles later -> live reg1=0x1234, changed=4'b0010 for one cycle, CTRL=0.
REQ-034 TIMEOUT=8, commit, no safe_point -> APPLY after 8 ARMED cycles.
REQ-035 Shadow write to reg0 coincident with APPLY -> live reg0 keeps old shadow value, CTRL reads 0x2 afterwards.
REQ-036 With AUTOCOMMIT_EN, write 0x1 to 0x0 then reset asserted while ARMED -> live reg0 = DEFAULTS, state IDLE, changed never pulses.
